// File: rtl/defines.sv
// Shared constants, FSM state type and access-legality helper for the
// handshaked MEM-stage data memory.
package defines;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_e;

    // High when the access is misaligned for its size or uses an unknown funct3.
    function automatic logic access_error(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic err;
        err = 1'b1;
        if (is_store) begin
            case (funct3)
                FUNCT3_SB: err = 1'b0;
                FUNCT3_SH: err = addr_lo[0];
                FUNCT3_SW: err = (addr_lo != 2'b00);
                default:   err = 1'b1;
            endcase
        end else begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LBU: err = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: err = addr_lo[0];
                FUNCT3_LW:             err = (addr_lo != 2'b00);
                default:               err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// Request/response bus of the handshaked data memory; the memory is the slave.
interface data_memory_hs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  MemWrite_en;
    logic                  MemRead_en;
    logic [2:0]            MEM_funct3_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rsp_valid_o;
    logic                  error_o;

    modport master (
        output req_valid_i, MemWrite_en, MemRead_en, MEM_funct3_i, addr_i, wr_data_i,
        input  req_ready_o, rd_data_o, rsp_valid_o, error_o
    );

    modport slave (
        input  req_valid_i, MemWrite_en, MemRead_en, MEM_funct3_i, addr_i, wr_data_i,
        output req_ready_o, rd_data_o, rsp_valid_o, error_o
    );
endinterface

// File: rtl/dmem_load_ext.sv
// RV32I load lane select with sign/zero extension; unknown funct3 yields zero.
module dmem_load_ext
    import defines::*;
(
    input  logic [DATA_WIDTH-1:0] mem_word,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        load_data = '0;
        case (funct3)
            FUNCT3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LBU: load_data = {24'h0, byte_sel};
            FUNCT3_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LHU: load_data = {16'h0, half_sel};
            FUNCT3_LW:  load_data = mem_word;
            default:    load_data = '0;
        endcase
    end
endmodule

// File: rtl/data_memory_hs.sv
// MEM-stage data memory with valid/ready requests, WAIT_STATES extra cycles
// before each access, RV32I load extension and misaligned/illegal error reporting.
module data_memory_hs #(
    parameter int DATA_WIDTH  = defines::DATA_WIDTH,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rst_n,
    data_memory_hs_if.slave bus
);
    import defines::*;

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [2:0] WAIT_LAST = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    mem_state_e state, next_state;
    logic [2:0] wait_cnt;
    logic       accept, do_access;

    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [IDX_W+1:0]      addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic                  cur_store, cur_err;
    logic [2:0]            cur_funct3;
    logic [IDX_W+1:0]      cur_addr;
    logic [DATA_WIDTH-1:0] cur_wr_data;

    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wr_lanes, rd_word, load_data, rd_data_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    assign accept = bus.req_valid_i && bus.req_ready_o && (bus.MemWrite_en || bus.MemRead_en);

    // Zero wait states access at the acceptance edge itself, so the live request is used.
    always_comb begin
        if (HAS_WAIT) begin
            cur_store   = is_store_q;
            cur_funct3  = funct3_q;
            cur_addr    = addr_q;
            cur_wr_data = wr_data_q;
        end else begin
            cur_store   = bus.MemWrite_en;
            cur_funct3  = bus.MEM_funct3_i;
            cur_addr    = bus.addr_i[IDX_W+1:0];
            cur_wr_data = bus.wr_data_i;
        end
    end

    if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_wrap
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.addr_i[ADDR_WIDTH-1:IDX_W+2];
    end

    assign cur_err   = access_error(cur_store, cur_funct3, cur_addr[1:0]);
    assign do_access = (next_state == RESP);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, RESP: next_state = accept ? (HAS_WAIT ? WAIT : RESP) : IDLE;
            WAIT:       if (wait_cnt == WAIT_LAST) next_state = RESP;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = (state != WAIT);
        bus.rsp_valid_o = (state == RESP);
        bus.error_o     = (state == RESP) && err_q;
        bus.rd_data_o   = rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
            if (accept) begin
                is_store_q <= bus.MemWrite_en;
                funct3_q   <= bus.MEM_funct3_i;
                addr_q     <= bus.addr_i[IDX_W+1:0];
                wr_data_q  <= bus.wr_data_i;
            end
            if (do_access) begin
                err_q <= cur_err;
                if (cur_err)         rd_data_q <= '0;
                else if (!cur_store) rd_data_q <= load_data;
            end
        end
    end

    // Right-aligned store data is replicated so each enabled lane sees its byte.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = cur_wr_data;
        case (cur_funct3)
            FUNCT3_SB: begin
                byte_en  = 4'b0001 << cur_addr[1:0];
                wr_lanes = {4{cur_wr_data[7:0]}};
            end
            FUNCT3_SH: begin
                byte_en  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{cur_wr_data[15:0]}};
            end
            FUNCT3_SW: byte_en = 4'b1111;
            default:   byte_en = 4'b0000;
        endcase
    end

    // NOTE: the array is deliberately outside rst_n so stored data survives a reset.
    always_ff @(posedge clk) begin
        if (do_access && cur_store && !cur_err) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byte_en[lane]) mem[cur_addr[IDX_W+1:2]][lane*8 +: 8] <= wr_lanes[lane*8 +: 8];
            end
        end
    end

    assign rd_word = mem[cur_addr[IDX_W+1:2]];

    dmem_load_ext u_load_ext (
        .mem_word  (rd_word),
        .addr_lo   (cur_addr[1:0]),
        .funct3    (cur_funct3),
        .load_data (load_data)
    );
endmodule

// File: tb/tb_data_memory_hs.sv
// Scoreboard bench: one data_memory_hs with no wait states and one with three,
// driven through a shared stimulus bus and checked against a byte-level model.
module tb_data_memory_hs;

    localparam int DEPTH = 1024;
    localparam int D0 = 0;   // WAIT_STATES = 0 instance
    localparam int D3 = 1;   // WAIT_STATES = 3 instance

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_BAD = 3'b011;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        valid, we, re;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [31:0] model [2][DEPTH];
    logic [31:0] last_rd [2];
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        mon_e0, mon_e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_hs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    data_memory_hs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.req_valid_i  = valid && (sel == D0);
    assign bus0.MemWrite_en  = we;
    assign bus0.MemRead_en   = re;
    assign bus0.MEM_funct3_i = f3;
    assign bus0.addr_i       = addr;
    assign bus0.wr_data_i    = wdata;
    assign bus3.req_valid_i  = valid && (sel == D3);
    assign bus3.MemWrite_en  = we;
    assign bus3.MemRead_en   = re;
    assign bus3.MEM_funct3_i = f3;
    assign bus3.addr_i       = addr;
    assign bus3.wr_data_i    = wdata;

    data_memory_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    data_memory_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic cur_ready(input int d);
        return (d == D0) ? bus0.req_ready_o : bus3.req_ready_o;
    endfunction

    function automatic int qsize(input int d);
        return (d == D0) ? q0.size() : q1.size();
    endfunction

    // Reference behaviour, applied in acceptance order; pushes the expected response.
    task automatic model_access(input int d, input logic store, input logic [2:0] fn,
                                input logic [31:0] a, input logic [31:0] wd, input int acc);
        int          idx;
        int          lo;
        logic        ok;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        exp_t        e;
        idx = int'(a[11:2]);
        lo  = int'(a[1:0]);
        w   = model[d][idx];
        if (store) ok = (fn == F_B) || (fn == F_H && lo % 2 == 0) || (fn == F_W && lo == 0);
        else       ok = (fn == F_B) || (fn == F_BU) || ((fn == F_H || fn == F_HU) && lo % 2 == 0)
                        || (fn == F_W && lo == 0);
        b = w[8*lo +: 8];
        h = w[16*(lo/2) +: 16];
        if (!ok) begin
            last_rd[d] = 32'h0;
        end else if (store) begin
            case (fn)
                F_B:     w[8*lo +: 8] = wd[7:0];
                F_H:     w[16*(lo/2) +: 16] = wd[15:0];
                default: w = wd;
            endcase
            model[d][idx] = w;
        end else begin
            case (fn)
                F_B:     last_rd[d] = {{24{b[7]}}, b};
                F_BU:    last_rd[d] = {24'h0, b};
                F_H:     last_rd[d] = {{16{h[15]}}, h};
                F_HU:    last_rd[d] = {16'h0, h};
                default: last_rd[d] = w;
            endcase
        end
        e = '{last_rd[d], !ok, acc};
        if (d == D0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Presents a request and holds it until accepted; returns cycles spent not ready and the accept cycle.
    task automatic req(input int d, input logic w_en, input logic r_en, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] wd, output int waits, output int acc);
        @(negedge clk);
        sel = d; we = w_en; re = r_en; f3 = fn; addr = a; wdata = wd; valid = 1'b1;
        waits = 0;
        while (!cur_ready(d) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            check("accept timeout", 32'(waits), 32'd0);
            valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc - 1;
        model_access(d, w_en, fn, a, wd, acc);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("response drain", 32'(qsize(d)), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " ws0 ready"}, {31'b0, bus0.req_ready_o}, 32'd1);
        check({tag, " ws0 rsp"},   {31'b0, bus0.rsp_valid_o}, 32'd0);
        check({tag, " ws0 err"},   {31'b0, bus0.error_o},     32'd0);
        check({tag, " ws0 rd"},    bus0.rd_data_o,            32'd0);
        check({tag, " ws3 ready"}, {31'b0, bus3.req_ready_o}, 32'd1);
        check({tag, " ws3 rsp"},   {31'b0, bus3.rsp_valid_o}, 32'd0);
        check({tag, " ws3 err"},   {31'b0, bus3.error_o},     32'd0);
        check({tag, " ws3 rd"},    bus3.rd_data_o,            32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus0.rsp_valid_o) begin
            if (q0.size() == 0) begin
                check("ws0 unexpected rsp", 32'd1, 32'd0);
            end else begin
                mon_e0 = q0.pop_front();
                check("ws0 rd_data", bus0.rd_data_o, mon_e0.data);
                check("ws0 error", {31'b0, bus0.error_o}, {31'b0, mon_e0.err});
                check("ws0 latency", 32'(cyc - mon_e0.acc), 32'd1);
            end
        end
        if (rst_n === 1'b1 && bus3.rsp_valid_o) begin
            if (q1.size() == 0) begin
                check("ws3 unexpected rsp", 32'd1, 32'd0);
            end else begin
                mon_e1 = q1.pop_front();
                check("ws3 rd_data", bus3.rd_data_o, mon_e1.data);
                check("ws3 error", {31'b0, bus3.error_o}, {31'b0, mon_e1.err});
                check("ws3 latency", 32'(cyc - mon_e1.acc), 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w1, w2, a1, a2;
        logic [31:0] saved;
        rst_n = 1'b0; valid = 1'b0; sel = D0; we = 1'b0; re = 1'b0;
        f3 = '0; addr = '0; wdata = '0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;

        // Single-cycle store then load, one request per cycle
        req(D0, 1, 0, F_W, 32'h100, 32'hDEADBEEF, w1, a1);
        req(D0, 0, 1, F_W, 32'h100, 32'h0, w2, a2);
        check("ws0 store ready", 32'(w1), 32'd0);
        check("ws0 load ready", 32'(w2), 32'd0);
        check("ws0 back-to-back", 32'(a2 - a1), 32'd1);

        // Byte stores over a prefilled word
        req(D0, 1, 0, F_W, 32'h300, 32'hFFFFFFFF, w1, a1);
        req(D0, 1, 0, F_B, 32'h300, 32'h00000011, w1, a1);
        req(D0, 1, 0, F_B, 32'h301, 32'hABCDEF22, w1, a1);
        req(D0, 1, 0, F_B, 32'h302, 32'h00000033, w1, a1);
        req(D0, 1, 1, F_B, 32'h303, 32'h00000044, w1, a1);
        req(D0, 0, 1, F_W, 32'h300, 32'h0, w1, a1);

        // Sign and zero extension
        req(D0, 1, 0, F_W,  32'h200, 32'h80F07F85, w1, a1);
        req(D0, 0, 1, F_B,  32'h200, 32'h0, w1, a1);
        req(D0, 0, 1, F_BU, 32'h200, 32'h0, w1, a1);
        req(D0, 0, 1, F_H,  32'h202, 32'h0, w1, a1);
        req(D0, 0, 1, F_HU, 32'h202, 32'h0, w1, a1);
        req(D0, 0, 1, F_B,  32'h201, 32'h0, w1, a1);
        req(D0, 1, 0, F_H,  32'h206, 32'h0000BEEF, w1, a1);
        req(D0, 0, 1, F_HU, 32'h206, 32'h0, w1, a1);

        // Misaligned and illegal accesses leave memory untouched
        req(D0, 1, 0, F_W,   32'h202, 32'h0BADF00D, w1, a1);
        req(D0, 0, 1, F_H,   32'h201, 32'h0, w1, a1);
        req(D0, 0, 1, F_BAD, 32'h200, 32'h0, w1, a1);
        req(D0, 1, 0, F_BAD, 32'h200, 32'h12121212, w1, a1);
        req(D0, 0, 1, F_W,   32'h200, 32'h0, w1, a1);

        // Addresses wrap modulo the array size
        req(D0, 1, 0, F_W, 32'h1000, 32'hA5A50001, w1, a1);
        req(D0, 0, 1, F_W, 32'h0000, 32'h0, w1, a1);
        req(D0, 1, 0, F_W, 32'h0004, 32'h5A5A0002, w1, a1);
        req(D0, 0, 1, F_W, 32'h1004, 32'h0, w1, a1);
        idle();
        drain(D0);

        // Three wait states: a held request is taken only in the RESP cycle
        req(D3, 1, 0, F_W, 32'h100, 32'hDEADBEEF, w1, a1);
        check("ws3 idle ready", 32'(w1), 32'd0);
        req(D3, 0, 1, F_W, 32'h100, 32'h0, w1, a1);
        req(D3, 1, 0, F_W, 32'h200, 32'h80F07F85, w2, a2);
        check("ws3 not-ready cycles", 32'(w2), 32'd3);
        check("ws3 accept in RESP", 32'(a2 - a1), 32'd4);
        req(D3, 0, 1, F_H, 32'h202, 32'h0, w1, a1);
        req(D3, 0, 1, F_B, 32'h201, 32'h0, w1, a1);
        req(D3, 0, 1, F_W, 32'h203, 32'h0, w1, a1);

        // Reset during WAIT drops the pending store
        req(D3, 1, 0, F_W, 32'h400, 32'hCAFEF00D, w1, a1);
        idle();
        drain(D3);
        drain(D0);
        saved = model[D3][32'h400 >> 2];
        req(D3, 1, 0, F_W, 32'h400, 32'h12345678, w1, a1);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        q1.delete();
        model[D3][32'h400 >> 2] = saved;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (2) @(negedge clk);
        check_reset("mid-wait reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post-reset ws3 ready", {31'b0, bus3.req_ready_o}, 32'd1);
        req(D3, 0, 1, F_W, 32'h400, 32'h0, w1, a1);
        req(D0, 0, 1, F_W, 32'h100, 32'h0, w1, a1);
        idle();
        drain(D3);
        drain(D0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
